pc_select_counter: RTL and testbench
====================================

PC_SELECT_COUNTER -- requirements
Module: pc_select_counter

Interface
REQ-001 Parameter ADDR_W, default 14, width of every address port and the PC register.
REQ-002 Parameter RESET_VECTOR, default 14'h0000, PC value loaded by reset.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 nreset  input  1  synchronous, active-high reset (1 = reset) sampled on the rising clock edge.
REQ-005 stall  input  1  1 = hold PC.
REQ-006 sel_signals  input  4  one-hot PC source select:
- bit0 = sequential
- bit1 = branch
- bit2 = interrupt
- bit3 = return
REQ-007 branch_target_addr  input  ADDR_W  branch destination.
REQ-008 int_branch_addr  input  ADDR_W  interrupt vector destination.
REQ-009 ret_addr  input  ADDR_W  return address from memory stage.
REQ-010 prog_mem_addr_fetch  output  ADDR_W  current PC, drives program-memory read address.
REQ-011 next_prog_cntr  output  ADDR_W  current PC + 1, also used as the return address to save.
REQ-012 sel_multi  output  1  1 when more than one sel_signals bit is set.

Function
REQ-013 prog_mem_addr_fetch SHALL equal the PC register directly (no combinational path from inputs).
REQ-014 next_prog_cntr SHALL be (PC + 1) modulo 2^ADDR_W; 14'h3FFF SHALL yield 14'h0000.
REQ-015 The combinational load value SHALL be selected by fixed priority:
- interrupt (bit2) > return (bit3) > branch (bit1) > sequential (bit0).
REQ-016 sel_signals == 4'b0000 SHALL select the sequential value (next_prog_cntr).
REQ-017 sel_multi SHALL be combinational, asserted for any sel_signals value with two or more bits set; it SHALL NOT alter the selection priority.
REQ-018 On a rising edge with nreset=0 and stall=0, PC SHALL load the selected value (one-cycle latency: the new address appears on prog_mem_addr_fetch the cycle after selection).
REQ-019 On a rising edge with nreset=0 and stall=1, PC SHALL hold, regardless of sel_signals or address inputs.
REQ-020 A redirect (branch/interrupt/return) presented while stall=1 SHALL be lost unless it is still presented when stall deasserts; the block SHALL NOT latch pending redirects.

Reset
REQ-021 nreset=1 at a rising edge SHALL load PC with RESET_VECTOR, overriding stall and every select.
REQ-022 During and after reset, until the next load: prog_mem_addr_fetch = RESET_VECTOR; next_prog_cntr = RESET_VECTOR + 1.
REQ-023 Reset asserted mid-operation SHALL take effect on the same edge; no other state exists.

Configuration
REQ-024 Macro PC_INT_SOURCE_EN:
- Defined: the interrupt source is implemented per REQ-015.
- Undefined: sel_signals bit2 SHALL be ignored (treated as 0 for both selection and sel_multi) and int_branch_addr SHALL be unused.

Verification
REQ-025 Reset, then 3 cycles with sel=4'b0001, stall=0 -> fetch addresses 0x0000, 0x0001, 0x0002, 0x0003; next_prog_cntr = fetch + 1.
REQ-026 PC=0x0005, sel=4'b0010, branch_target_addr=0x1234 -> next cycle fetch = 0x1234, next_prog_cntr = 0x1235.
REQ-027 PC=0x0010, stall=1 for 3 cycles with sel=4'b0010 and branch_target_addr=0x0200 -> fetch stays 0x0010; stall=0 with sel=4'b0001 -> 0x0011.
REQ-028 sel=4'b1110, int_branch_addr=0x3F00, ret_addr=0x0040, branch_target_addr=0x0100 -> sel_multi=1; next fetch = 0x3F00 (with PC_INT_SOURCE_EN defined), 0x0040 (without).
REQ-029 PC=0x3FFF, sel=4'b0001 -> next_prog_cntr=0x0000; next fetch = 0x0000.
REQ-030 PC=0x0ABC, stall=1, nreset=1 for one edge -> fetch = 0x0000 on the following cycle.

Source files
------------

// File: rtl/pc_select_counter.sv
// Program counter with one-hot source select: interrupt > return > branch > sequential, one-cycle load, stall holds.
// Define PC_INT_SOURCE_EN to build the interrupt source; otherwise sel_signals[2] and int_branch_addr are ignored.
module pc_select_counter #(
  parameter int                ADDR_W       = 14,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              stall,
  input  logic [3:0]        sel_signals,
  input  logic [ADDR_W-1:0] branch_target_addr,
  input  logic [ADDR_W-1:0] int_branch_addr,
  input  logic [ADDR_W-1:0] ret_addr,
  output logic [ADDR_W-1:0] prog_mem_addr_fetch,
  output logic [ADDR_W-1:0] next_prog_cntr,
  output logic              sel_multi
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] load_val;
  logic              int_sel;
  logic [3:0]        sel_eff;

`ifdef PC_INT_SOURCE_EN
  assign int_sel = sel_signals[2];
`else
  // Interrupt source not built: its select bit and vector are deliberately dropped.
  logic unused_int;
  assign int_sel    = 1'b0;
  assign unused_int = ^{sel_signals[2], int_branch_addr};
`endif

  assign sel_eff = {sel_signals[3], int_sel, sel_signals[1:0]};

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign sel_multi = |(sel_eff & (sel_eff - 4'd1));

  assign prog_mem_addr_fetch = pc;
  assign next_prog_cntr      = pc + ADDR_W'(1);

  always_comb begin
    load_val = next_prog_cntr;
`ifdef PC_INT_SOURCE_EN
    if (int_sel)
      load_val = int_branch_addr;
    else
`endif
    if (sel_eff[3])
      load_val = ret_addr;
    else if (sel_eff[1])
      load_val = branch_target_addr;
  end

  always_ff @(posedge clock) begin
    if (nreset)
      pc <= RESET_VECTOR;
    else if (!stall)
      pc <= load_val;
  end

endmodule

// File: tb/tb_pc_select_counter.sv
// Directed bench for pc_select_counter; expected values are hand-computed constants.
module tb_pc_select_counter;

  logic        clock;
  logic        nreset;
  logic        stall;
  logic [3:0]  sel_signals;
  logic [13:0] branch_target_addr;
  logic [13:0] int_branch_addr;
  logic [13:0] ret_addr;
  logic [13:0] prog_mem_addr_fetch;
  logic [13:0] next_prog_cntr;
  logic        sel_multi;

  int total = 0;
  int bad   = 0;

  pc_select_counter dut (
    .clock              (clock),
    .nreset             (nreset),
    .stall              (stall),
    .sel_signals        (sel_signals),
    .branch_target_addr (branch_target_addr),
    .int_branch_addr    (int_branch_addr),
    .ret_addr           (ret_addr),
    .prog_mem_addr_fetch(prog_mem_addr_fetch),
    .next_prog_cntr     (next_prog_cntr),
    .sel_multi          (sel_multi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic jump(input logic [13:0] addr);
    stall = 1'b0;
    sel_signals = 4'b0010;
    branch_target_addr = addr;
    step();
  endtask

  initial begin
    nreset = 1'b1;
    stall = 1'b0;
    sel_signals = 4'b0001;
    branch_target_addr = '0;
    int_branch_addr = '0;
    ret_addr = '0;
    step();
    step();
    check("reset_fetch", prog_mem_addr_fetch, 32'h0000);
    check("reset_npc", next_prog_cntr, 32'h0001);
    check("reset_multi", sel_multi, 0);

    // Sequential run
    nreset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      check("seq_fetch", prog_mem_addr_fetch, i);
      check("seq_npc", next_prog_cntr, i + 1);
    end

    // Branch from 0x0005
    jump(14'h0005);
    check("pc_at_5", prog_mem_addr_fetch, 32'h0005);
    jump(14'h1234);
    check("branch_fetch", prog_mem_addr_fetch, 32'h1234);
    check("branch_npc", next_prog_cntr, 32'h1235);

    // Stall drops a redirect
    jump(14'h0010);
    stall = 1'b1;
    sel_signals = 4'b0010;
    branch_target_addr = 14'h0200;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_hold", prog_mem_addr_fetch, 32'h0010);
    end
    stall = 1'b0;
    sel_signals = 4'b0001;
    step();
    check("stall_release", prog_mem_addr_fetch, 32'h0011);

    sel_signals = 4'b0000;
    #1;
    check("zero_sel_multi", sel_multi, 0);
    step();
    check("zero_sel_seq", prog_mem_addr_fetch, 32'h0012);

    // Multi-select priority
    sel_signals = 4'b1110;
    int_branch_addr = 14'h3F00;
    ret_addr = 14'h0040;
    branch_target_addr = 14'h0100;
    #1;
    check("multi_1110", sel_multi, 1);
    step();
`ifdef PC_INT_SOURCE_EN
    check("prio_1110", prog_mem_addr_fetch, 32'h3F00);
`else
    check("prio_1110", prog_mem_addr_fetch, 32'h0040);
`endif

    sel_signals = 4'b1010;
    #1;
    check("multi_1010", sel_multi, 1);
    step();
    check("prio_ret_over_branch", prog_mem_addr_fetch, 32'h0040);

    jump(14'h0020);
    sel_signals = 4'b0101;
    #1;
`ifdef PC_INT_SOURCE_EN
    check("multi_0101", sel_multi, 1);
    step();
    check("int_over_seq", prog_mem_addr_fetch, 32'h3F00);
`else
    check("multi_0101", sel_multi, 0);
    step();
    check("int_ignored", prog_mem_addr_fetch, 32'h0021);
`endif

    sel_signals = 4'b0100;
    #1;
    check("multi_0100", sel_multi, 0);

    // Wrap at top of address space
    jump(14'h3FFF);
    sel_signals = 4'b0001;
    #1;
    check("wrap_npc", next_prog_cntr, 32'h0000);
    step();
    check("wrap_fetch", prog_mem_addr_fetch, 32'h0000);

    // Reset overrides stall mid-operation
    jump(14'h0ABC);
    check("pc_at_abc", prog_mem_addr_fetch, 32'h0ABC);
    stall = 1'b1;
    nreset = 1'b1;
    step();
    check("reset_mid_fetch", prog_mem_addr_fetch, 32'h0000);
    check("reset_mid_npc", next_prog_cntr, 32'h0001);
    nreset = 1'b0;
    stall = 1'b0;
    sel_signals = 4'b0001;
    step();
    check("post_reset_seq", prog_mem_addr_fetch, 32'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
